// File: rtl/seq_match_det_pkg.sv
// seq_match_pkg: shared constants, width helper and masked symbol compare
package seq_match_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic masked_eq(input logic [31:0] s, input logic [31:0] p, input logic [31:0] m);
    return ((s ^ p) & m) == 32'd0;
  endfunction
endpackage

// File: rtl/seq_match_det_if.sv
// seq_match_det_if: config, symbol stream and match status bundle
interface seq_match_det_if import seq_match_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
);
  localparam int IDX_W  = clog2(DEPTH);
  localparam int FILL_W = clog2(DEPTH + 1);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [WIDTH-1:0]  cfg_sym;
  logic [WIDTH-1:0]  cfg_mask;
  logic              overlap;
  logic              in_valid;
  logic [WIDTH-1:0]  in_sym;
  logic              cnt_clr;
  logic              match;
  logic              armed;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  match_cnt;
  modport master (
    output cfg_we, cfg_idx, cfg_sym, cfg_mask, overlap, in_valid, in_sym, cnt_clr,
    input  match, armed, fill, match_cnt
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_sym, cfg_mask, overlap, in_valid, in_sym, cnt_clr,
    output match, armed, fill, match_cnt
  );
endinterface

// File: rtl/seq_match_det_cmp.sv
// seq_match_cmp: single-slot masked symbol comparator
module seq_match_cmp import seq_match_pkg::*; #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] sym,
  input  logic [WIDTH-1:0] pat,
  input  logic [WIDTH-1:0] mask,
  output logic             eq
);
  assign eq = masked_eq(32'(sym), 32'(pat), 32'(mask));
endmodule

// File: rtl/seq_match_det.sv
// seq_match_det: programmable masked sequence detector with saturating match counter
module seq_match_det import seq_match_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  seq_match_det_if.slave bus
);
  localparam int FILL_W = clog2(DEPTH + 1);
  logic [WIDTH-1:0]  win_q [DEPTH];
  logic [WIDTH-1:0]  win_d [DEPTH];
  logic [WIDTH-1:0]  win_nx [DEPTH];
  logic [WIDTH-1:0]  pat_q [DEPTH];
  logic [WIDTH-1:0]  pat_d [DEPTH];
  logic [WIDTH-1:0]  mask_q [DEPTH];
  logic [WIDTH-1:0]  mask_d [DEPTH];
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              match_q, match_d;
  logic [DEPTH-1:0]  eq;
  logic              accept, hit;
  // Compare against the post-shift window so the hit lines up with the accepting edge
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i == DEPTH - 1) begin : g_new
      assign win_nx[i] = bus.in_sym;
    end else begin : g_old
      assign win_nx[i] = win_q[i+1];
    end
    seq_match_cmp #(.WIDTH(WIDTH)) u_cmp (
      .sym  (win_nx[i]),
      .pat  (pat_q[i]),
      .mask (mask_q[i]),
      .eq   (eq[i])
    );
  end
  always_comb begin
    accept   = bus.in_valid & ~bus.cfg_we;
    fill_inc = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + 1'b1;
    hit      = (accept && fill_inc == FILL_W'(DEPTH) && &eq) ? TRUE : FALSE;
    for (int k = 0; k < DEPTH; k++) begin
      win_d[k]  = accept ? win_nx[k] : win_q[k];
      pat_d[k]  = pat_q[k];
      mask_d[k] = mask_q[k];
    end
    if (bus.cfg_we && 32'(bus.cfg_idx) < DEPTH) begin
      pat_d[bus.cfg_idx]  = bus.cfg_sym;
      mask_d[bus.cfg_idx] = bus.cfg_mask;
    end
    fill_d  = bus.cfg_we ? '0 : !accept ? fill_q : (hit && !bus.overlap) ? '0 : fill_inc;
    match_d = hit;
    cnt_d   = bus.cnt_clr ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        win_q[k]  <= '0;
        pat_q[k]  <= '0;
        mask_q[k] <= '1;
      end
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        win_q[k]  <= win_d[k];
        pat_q[k]  <= pat_d[k];
        mask_q[k] <= mask_d[k];
      end
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.match     = match_q;
  assign bus.armed     = (fill_q == FILL_W'(DEPTH));
  assign bus.fill      = fill_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_match_det.sv
// tb_seq_match_det: directed scoreboard bench for seq_match_det, plus a CNT_W=2 twin for saturation
module tb_seq_match_det;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic exp_q [$];
  always #5 clk = ~clk;
  seq_match_det_if #(.WIDTH(2), .DEPTH(3), .CNT_W(8)) bus ();
  seq_match_det_if #(.WIDTH(2), .DEPTH(3), .CNT_W(2)) bus2 ();
  assign bus2.cfg_we   = bus.cfg_we;
  assign bus2.cfg_idx  = bus.cfg_idx;
  assign bus2.cfg_sym  = bus.cfg_sym;
  assign bus2.cfg_mask = bus.cfg_mask;
  assign bus2.overlap  = bus.overlap;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_sym   = bus.in_sym;
  assign bus2.cnt_clr  = bus.cnt_clr;
  seq_match_det #(.WIDTH(2), .DEPTH(3), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  seq_match_det #(.WIDTH(2), .DEPTH(3), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(bus2));
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [1:0] s, input logic e);
    bus.in_valid = v;
    bus.in_sym   = s;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("match", int'(bus.match), int'(exp_q.pop_front()));
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
  endtask
  task automatic cfg(input logic [1:0] idx, input logic [1:0] sym, input logic [1:0] mask,
                     input logic v, input logic [1:0] s);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx;
    bus.cfg_sym  = sym;
    bus.cfg_mask = mask;
    step(v, s, 1'b0);
    chk("cfg_fill", int'(bus.fill), 0);
    bus.cfg_we = 1'b0;
  endtask
  task automatic pat(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    cfg(2'd0, a, 2'd3, 1'b0, 2'd0);
    cfg(2'd1, b, 2'd3, 1'b0, 2'd0);
    cfg(2'd2, c, 2'd3, 1'b0, 2'd0);
  endtask
  initial begin
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_sym = 0; bus.cfg_mask = 0;
    bus.overlap = 1; bus.in_valid = 0; bus.in_sym = 0; bus.cnt_clr = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_match", int'(bus.match), 0);
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_fill", int'(bus.fill), 0);
    chk("rst_cnt", int'(bus.match_cnt), 0);
    // basic 1,2,3
    pat(2'd1, 2'd2, 2'd3);
    step(1, 2'd1, 0);
    step(1, 2'd2, 0);
    chk("basic_fill2", int'(bus.fill), 2);
    chk("basic_armed_lo", int'(bus.armed), 0);
    step(1, 2'd3, 1);
    chk("basic_cnt", int'(bus.match_cnt), 1);
    chk("basic_armed", int'(bus.armed), 1);
    step(0, 2'd0, 0);
    // overlapping 1,1,1
    pat(2'd1, 2'd1, 2'd1);
    bus.cnt_clr = 1'b1;
    step(0, 2'd0, 0);
    chk("clr_cnt", int'(bus.match_cnt), 0);
    step(1, 2'd1, 0); step(1, 2'd1, 0);
    step(1, 2'd1, 1); step(1, 2'd1, 1); step(1, 2'd1, 1);
    chk("ovl_cnt", int'(bus.match_cnt), 3);
    chk("ovl_fill", int'(bus.fill), 3);
    // non-overlapping
    cfg(2'd0, 2'd1, 2'd3, 1'b0, 2'd0);
    bus.overlap = 1'b0;
    step(1, 2'd1, 0); step(1, 2'd1, 0);
    step(1, 2'd1, 1); step(1, 2'd1, 0); step(1, 2'd1, 0);
    chk("novl_cnt", int'(bus.match_cnt), 4);
    chk("novl_fill", int'(bus.fill), 2);
    // gaps
    bus.overlap = 1'b1;
    pat(2'd1, 2'd2, 2'd3);
    step(1, 2'd1, 0);
    repeat (4) step(0, 2'd2, 0);
    step(1, 2'd2, 0);
    repeat (4) step(0, 2'd0, 0);
    chk("gap_fill", int'(bus.fill), 2);
    step(1, 2'd3, 1);
    chk("gap_cnt", int'(bus.match_cnt), 5);
    // don't-care middle slot
    cfg(2'd1, 2'd2, 2'd0, 1'b0, 2'd0);
    step(1, 2'd1, 0); step(1, 2'd0, 0); step(1, 2'd3, 1);
    step(1, 2'd1, 0); step(1, 2'd3, 0); step(1, 2'd3, 1);
    chk("mask_cnt", int'(bus.match_cnt), 7);
    chk("sat_cnt", int'(bus2.match_cnt), 3);
    // clear coincident with a hit
    step(1, 2'd1, 0); step(1, 2'd0, 0);
    bus.cnt_clr = 1'b1;
    step(1, 2'd3, 1);
    chk("clrhit_cnt", int'(bus.match_cnt), 0);
    chk("clrhit_sat_match", int'(bus2.match), 1);
    chk("clrhit_sat_cnt", int'(bus2.match_cnt), 0);
    // async reset mid-sequence
    step(1, 2'd1, 0); step(1, 2'd2, 0);
    chk("pre_rst_fill", int'(bus.fill), 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_fill", int'(bus.fill), 0);
    chk("arst_armed", int'(bus.armed), 0);
    chk("arst_match", int'(bus.match), 0);
    #1 rst = 1'b0;
    step(1, 2'd3, 0);
    chk("post_rst_fill", int'(bus.fill), 1);
    // config write during a stream drops the symbol
    pat(2'd1, 2'd2, 2'd3);
    step(1, 2'd1, 0); step(1, 2'd2, 0);
    cfg(2'd2, 2'd3, 2'd3, 1'b1, 2'd3);
    step(0, 2'd0, 0);
    chk("cfg_drop_fill", int'(bus.fill), 0);
    // out-of-range slot still flushes but leaves the pattern alone
    step(1, 2'd1, 0); step(1, 2'd2, 0);
    cfg(2'd3, 2'd0, 2'd3, 1'b0, 2'd0);
    step(1, 2'd1, 0); step(1, 2'd2, 0); step(1, 2'd3, 1);
    chk("oor_cnt", int'(bus.match_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
